// File: rtl/gpio_out_sequencer.sv
// Four-pattern generator for the 32-bit GPIO header, advanced by a prescaled tick or a debounced-free
// single-step button; pushbuttons are synchronised and edge-detected, GPIO and tick are fully registered.
module gpio_out_sequencer #(
  parameter int TICK_COUNT = 5000000,
  parameter int CNT_WIDTH  = 26
) (
  input  logic        CLOCK_50,
  input  logic        Resetn,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [7:0]  seed,
  input  logic        load_n,
  input  logic        step_n,
  output logic [31:0] GPIO,
  output logic        tick
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TICK_COUNT - 1);

  logic                 ld_s1_q, ld_s2_q, ld_hist_q;
  logic                 ld_s1_d, ld_s2_d, ld_hist_d;
  logic                 st_s1_q, st_s2_q, st_hist_q;
  logic                 st_s1_d, st_s2_d, st_hist_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          gpio_q, gpio_d;
  logic                 tick_q, tick_d;

  logic        ld_press, st_press, adv_auto, adv;
  logic [31:0] next_val;

  always_comb begin
    ld_s1_d   = load_n;
    ld_s2_d   = ld_s1_q;
    ld_hist_d = ld_s2_q;
    st_s1_d   = step_n;
    st_s2_d   = st_s1_q;
    st_hist_d = st_s2_q;

    // One pulse per falling edge of the synchronised button
    ld_press = ld_hist_q & ~ld_s2_q;
    st_press = st_hist_q & ~st_s2_q;

    adv_auto = enable && (cnt_q == CNT_LAST);
    cnt_d    = '0;
    if (enable && !adv_auto) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    adv = enable ? adv_auto : st_press;

    next_val = gpio_q;
    case (mode)
      2'd0: next_val = gpio_q + 32'd1;
      2'd1: next_val = (gpio_q == 32'h0) ? 32'h1 : {gpio_q[30:0], gpio_q[31]};
      2'd2: next_val = (gpio_q == 32'h0) ? 32'h1 :
                       {gpio_q[30:0], gpio_q[31] ^ gpio_q[21] ^ gpio_q[1] ^ gpio_q[0]};
      default: next_val = ~gpio_q;
    endcase

    gpio_d = gpio_q;
    tick_d = 1'b0;
    if (ld_press) begin
      // An all-zero LFSR state would lock up, so a zero seed in LFSR mode becomes 1
      gpio_d = ((mode == 2'd2) && (seed == 8'h0)) ? 32'h1 : {24'h0, seed};
      tick_d = 1'b1;
    end else if (adv) begin
      gpio_d = next_val;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge Resetn) begin
    if (!Resetn) begin
      ld_s1_q   <= 1'b1;
      ld_s2_q   <= 1'b1;
      ld_hist_q <= 1'b1;
      st_s1_q   <= 1'b1;
      st_s2_q   <= 1'b1;
      st_hist_q <= 1'b1;
      cnt_q     <= '0;
      gpio_q    <= 32'h0;
      tick_q    <= 1'b0;
    end else begin
      ld_s1_q   <= ld_s1_d;
      ld_s2_q   <= ld_s2_d;
      ld_hist_q <= ld_hist_d;
      st_s1_q   <= st_s1_d;
      st_s2_q   <= st_s2_d;
      st_hist_q <= st_hist_d;
      cnt_q     <= cnt_d;
      gpio_q    <= gpio_d;
      tick_q    <= tick_d;
    end
  end

  assign GPIO = gpio_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_gpio_out_sequencer.sv
// Bench for gpio_out_sequencer: directed scenarios plus random stimulus against a behavioural model.
module tb_gpio_out_sequencer;

  localparam int TC = 4;

  logic        CLOCK_50 = 1'b0;
  logic        Resetn   = 1'b0;
  logic        enable   = 1'b0;
  logic [1:0]  mode     = 2'd0;
  logic [7:0]  seed     = 8'h0;
  logic        load_n   = 1'b1;
  logic        step_n   = 1'b1;
  logic [31:0] GPIO;
  logic        tick;

  int n_chk = 0;
  int n_err = 0;

  gpio_out_sequencer #(.TICK_COUNT(TC), .CNT_WIDTH(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .enable   (enable),
    .mode     (mode),
    .seed     (seed),
    .load_n   (load_n),
    .step_n   (step_n),
    .GPIO     (GPIO),
    .tick     (tick)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Reference model: expected pattern, cycles of enabled running, recent button samples
  logic [31:0] m_gpio = 32'h0;
  bit          m_tick = 1'b0;
  int          m_run  = 0;
  bit          l1 = 1, l2 = 1, l3 = 1;
  bit          s1 = 1, s2 = 1, s3 = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] pattern_next(input logic [1:0] md, input logic [31:0] g);
    case (md)
      2'd0: return g + 32'd1;
      2'd1: return (g == 0) ? 32'h1 : ((g << 1) | (g >> 31));
      2'd2: return (g == 0) ? 32'h1 : ((g << 1) | 32'(g[31] ^ g[21] ^ g[1] ^ g[0]));
      default: return ~g;
    endcase
  endfunction

  task automatic model_reset();
    m_gpio = 32'h0;
    m_tick = 1'b0;
    m_run  = 0;
    l1 = 1; l2 = 1; l3 = 1;
    s1 = 1; s2 = 1; s3 = 1;
  endtask

  task automatic model_edge();
    bit lp, sp, auto, adv;
    // A press takes effect two edges after the first low sample, once per falling edge
    lp = !l2 && l3;
    sp = !s2 && s3;
    l3 = l2; l2 = l1; l1 = load_n;
    s3 = s2; s2 = s1; s1 = step_n;
    auto = 1'b0;
    if (enable) begin
      m_run++;
      if (m_run == TC) begin
        auto  = 1'b1;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    adv    = enable ? auto : sp;
    m_tick = 1'b0;
    if (lp) begin
      m_gpio = (mode == 2'd2 && seed == 8'h0) ? 32'h1 : {24'h0, seed};
      m_tick = 1'b1;
    end else if (adv) begin
      m_gpio = pattern_next(mode, m_gpio);
      m_tick = 1'b1;
    end
  endtask

  task automatic step_cyc();
    @(posedge CLOCK_50);
    if (Resetn) model_edge();
    @(negedge CLOCK_50);
    chk("gpio", GPIO, m_gpio);
    chk("tick", 32'(tick), 32'(m_tick));
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    #1;
    chk("rst_gpio", GPIO, 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    model_reset();
    step_cyc();
    step_cyc();
    Resetn = 1'b1;
  endtask

  task automatic pulse_load();
    load_n = 1'b0;
    step_cyc();
    load_n = 1'b1;
    repeat (4) step_cyc();
  endtask

  task automatic pulse_step();
    step_n = 1'b0;
    step_cyc();
    step_n = 1'b1;
    repeat (4) step_cyc();
  endtask

  initial begin
    int ticks, advs, first, c;

    // Idle after reset: nothing moves
    repeat (3) step_cyc();
    Resetn = 1'b1;
    ticks = 0;
    repeat (20) begin
      step_cyc();
      ticks += int'(tick);
    end
    chk("idle_ticks", 32'(ticks), 32'd0);
    chk("idle_gpio", GPIO, 32'h0);

    // Counter mode free-run, updates every TC cycles
    do_reset();
    enable = 1'b1;
    ticks  = 0;
    for (int i = 1; i <= 12; i++) begin
      step_cyc();
      if (tick) begin
        ticks++;
        chk("tick_pos", 32'(i), 32'(ticks * TC));
      end
    end
    chk("cnt_ticks", 32'(ticks), 32'd3);
    chk("cnt_val", GPIO, 32'h3);

    // Counter wrap: 0 -> complement -> +1
    enable = 1'b0;
    seed   = 8'h00;
    pulse_load();
    chk("ld_zero", GPIO, 32'h0);
    mode = 2'd3;
    pulse_step();
    chk("cpl_ones", GPIO, 32'hFFFF_FFFF);
    mode = 2'd0;
    pulse_step();
    chk("cnt_wrap", GPIO, 32'h0);

    // Walking one: load latency and wrap from bit 31 to bit 0
    enable = 1'b1;
    mode   = 2'd1;
    seed   = 8'h80;
    load_n = 1'b0;
    step_cyc();
    load_n = 1'b1;
    step_cyc();
    step_cyc();
    chk("ld_latency", GPIO, 32'h80);
    advs = 0;
    for (int i = 0; i < 200 && advs < 25; i++) begin
      step_cyc();
      if (m_tick) advs++;
    end
    chk("rot_count", 32'(advs), 32'd25);
    chk("rot_wrap", GPIO, 32'h1);

    // LFSR: zero seed forced to 1, single steps, held button steps once
    enable = 1'b0;
    mode   = 2'd2;
    seed   = 8'h00;
    pulse_load();
    chk("lfsr_seed", GPIO, 32'h1);
    repeat (3) pulse_step();
    ticks  = 0;
    step_n = 1'b0;
    repeat (50) begin
      step_cyc();
      ticks += int'(tick);
    end
    step_n = 1'b1;
    repeat (4) begin
      step_cyc();
      ticks += int'(tick);
    end
    chk("hold_once", 32'(ticks), 32'd1);

    // Step presses ignored while running
    enable = 1'b1;
    mode   = 2'd0;
    ticks  = 0;
    for (int i = 0; i < 16; i++) begin
      step_n = (i % 3) != 0;
      step_cyc();
      ticks += int'(tick);
    end
    step_n = 1'b1;
    chk("step_ignored", 32'(ticks), 32'd4);

    // Load press landing on the same edge as an automatic advance
    for (int i = 0; i < 10 && m_run != 1; i++) step_cyc();
    chk("align_run", 32'(m_run), 32'd1);
    seed   = 8'h5A;
    load_n = 1'b0;
    step_cyc();
    load_n = 1'b1;
    step_cyc();
    step_cyc();
    chk("coin_gpio", GPIO, 32'h5A);
    c = int'(tick);
    step_cyc();
    c += int'(tick);
    chk("coin_tick", 32'(c), 32'd1);

    // Asynchronous reset right after a write, then first advance timing
    enable = 1'b0;
    seed   = 8'hA5;
    load_n = 1'b0;
    step_cyc();
    load_n = 1'b1;
    step_cyc();
    step_cyc();
    chk("pre_rst_gpio", GPIO, 32'hA5);
    chk("pre_rst_tick", 32'(tick), 32'd1);
    enable = 1'b1;
    do_reset();
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      step_cyc();
      if (tick && first == 0) first = i;
    end
    chk("rst_first_adv", 32'(first), 32'(TC));

    // Random stimulus against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) load_n = ~load_n;
      if ($urandom_range(0, 4) == 0) step_n = ~step_n;
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) seed = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) seed = 8'h00;
      step_cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
